// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the MAR/MDR bus master: state encodings, bus width,
// latched request layout.
package mem_bus_master_pkg;

    localparam int BUS_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_MAR  = 3'd1,
        ST_RD_MEM  = 3'd2,
        ST_RD_GATE = 3'd3,
        ST_WR_MDR  = 3'd4,
        ST_WR_MEM  = 3'd5,
        ST_DONE    = 3'd6
    } mbm_state_e;

    typedef struct packed {
        logic             we;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] wdata;
    } mbm_req_t;

    // Only these two states put master data on the shared bus.
    function automatic logic drives_bus(input mbm_state_e s);
        return (s == ST_LD_MAR) || (s == ST_WR_MDR);
    endfunction

endpackage

// File: rtl/mem_bus_master_tsb.sv
// Tri-state bus driver: drives d onto y while en is high, otherwise releases it.
module tsb_h #(
    parameter int W = 16
) (
    input  logic [W-1:0] d,
    input  logic         en,
    inout  wire  [W-1:0] y
);

    assign y = en ? d : {W{1'bz}};

endmodule

// File: rtl/mem_bus_master.sv
// Non-CPU initiator on the LC-3 MAR/MDR memory interface: single-word read/write
// over a req/ack port, bus arbitration with the CPU, bounded wait on rdy.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             req,
    input  logic             req_we,
    input  logic [BUS_W-1:0] req_addr,
    input  logic [BUS_W-1:0] req_wdata,
    output logic             ack,
    output logic             err,
    output logic [BUS_W-1:0] rdata,
    output logic             busy,
    output logic             bus_req,
    input  logic             bus_gnt,
    inout  wire  [BUS_W-1:0] bus,
    input  logic             mem_rdy,
    output logic             mem_ld_mar,
    output logic             mem_ld_mdr,
    output logic             mem_gate_mdr,
    output logic             mem_mio_en,
    output logic             mem_rw
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mbm_state_e       state, state_nxt;
    mbm_req_t         lat_q;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             err_q, err_nxt;
    logic [BUS_W-1:0] rdata_q;
    logic             accept, capture;
    logic [BUS_W-1:0] drv_data;
    logic             drv_en;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= ST_IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            err_q <= err_nxt;
            if (accept)
                lat_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
            if (capture)
                rdata_q <= bus;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                err_nxt = 1'b0;
                if (req && bus_gnt) begin
                    accept    = 1'b1;
                    state_nxt = ST_LD_MAR;
                end
            end
            ST_LD_MAR: begin
                cnt_nxt   = '0;
                state_nxt = lat_q.we ? ST_WR_MDR : ST_RD_MEM;
            end
            ST_WR_MDR: begin
                cnt_nxt   = '0;
                state_nxt = ST_WR_MEM;
            end
            ST_RD_MEM, ST_WR_MEM: begin
                if (mem_rdy) begin
                    state_nxt = (state == ST_RD_MEM) ? ST_RD_GATE : ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            ST_RD_GATE: begin
                capture   = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Losing the grant mid-transaction overrides every other transition.
        if (state != ST_IDLE && state != ST_DONE && !bus_gnt) begin
            state_nxt = ST_DONE;
            err_nxt   = 1'b1;
            capture   = 1'b0;
        end
    end

    always_comb begin
        mem_ld_mar   = 1'b0;
        mem_ld_mdr   = 1'b0;
        mem_gate_mdr = 1'b0;
        mem_mio_en   = 1'b0;
        mem_rw       = 1'b0;
        unique case (state)
            ST_LD_MAR:  mem_ld_mar = 1'b1;
            ST_RD_MEM: begin
                mem_mio_en = 1'b1;
                mem_ld_mdr = 1'b1;
            end
            ST_RD_GATE: mem_gate_mdr = 1'b1;
            ST_WR_MDR:  mem_ld_mdr = 1'b1;
            ST_WR_MEM: begin
                mem_mio_en = 1'b1;
                mem_rw     = 1'b1;
            end
            default: ;
        endcase
    end

    assign ack     = (state == ST_DONE);
    assign err     = ack & err_q;
    assign busy    = (state != ST_IDLE);
    assign bus_req = (state == ST_IDLE) ? req : (state != ST_DONE);
    assign rdata   = rdata_q;

    assign drv_data = (state == ST_WR_MDR) ? lat_q.wdata : lat_q.addr;
    assign drv_en   = drives_bus(state) & bus_gnt;

    tsb_h #(.W(BUS_W)) u_bus_drv (
        .d  (drv_data),
        .en (drv_en),
        .y  (bus)
    );

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: LC-3 style MAR/MDR memory model plus an
// ack-driven scoreboard checking err, rdata and acceptance-to-ack latency.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req = 1'b0, req_we = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        ack, err, busy, bus_req;
    logic [15:0] rdata;
    logic        bus_gnt = 1'b1;
    wire  [15:0] bus;
    logic        rdy = 1'b1;
    logic        mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw;

    always #5 clk = ~clk;

    mem_bus_master #(.TIMEOUT(8), .CNT_W(5)) dut (
        .clk(clk), .arst_n(arst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .err(err),
        .rdata(rdata), .busy(busy), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus(bus), .mem_rdy(rdy), .mem_ld_mar(mem_ld_mar),
        .mem_ld_mdr(mem_ld_mdr), .mem_gate_mdr(mem_gate_mdr),
        .mem_mio_en(mem_mio_en), .mem_rw(mem_rw)
    );

    // Memory model: MAR/MDR registers, 256-word array indexed by MAR[7:0].
    logic [15:0] ram [0:255];
    logic [15:0] mar = '0, mdr = '0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    assign bus = mem_gate_mdr ? mdr : 16'hzzzz;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        if (mem_ld_mar) mar <= bus;
        if (mem_ld_mdr) begin
            if (mem_mio_en) begin
                if (rdy) mdr <= ram[mar[7:0]];
            end else begin
                mdr <= bus;
            end
        end
        if (mem_mio_en && mem_rw && rdy) ram[mar[7:0]] <= mdr;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic bus_free();
        return (bus === 16'hzzzz) || (bus === 16'h0000);
    endfunction

    // {ld_mar, ld_mdr, mio_en, rw, gate_mdr} per cycle after acceptance, rdy high.
    function automatic logic [4:0] exp_tr(input logic we, input int c);
        case (c)
            1:       return 5'b10000;
            2:       return we ? 5'b01000 : 5'b01100;
            3:       return we ? 5'b00110 : 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   lat_cnt = 0;

    always @(negedge clk) begin
        if (!arst_n || !busy) lat_cnt = 0;
        else lat_cnt++;
        if (ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_err", 32'(err), 32'(e.err));
                check("ack_rdata", 32'(rdata), 32'(e.rdata));
                check("ack_latency", 32'(lat_cnt), 32'(e.lat));
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input int rdy_low, input logic [15:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input logic chk_trace, input int gnt_drop,
                       output int mio_cyc, output logic [4:0] ack_sig);
        exp_t e;
        logic [4:0] sig;
        logic got;
        e.err = exp_err; e.rdata = exp_rdata; e.lat = exp_lat;
        sb.push_back(e);
        mio_cyc = 0; ack_sig = '0; got = 1'b0;
        rdy = (rdy_low == 0);
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            sig = {mem_ld_mar, mem_ld_mdr, mem_mio_en, mem_rw, mem_gate_mdr};
            if (chk_trace && c <= 4) begin
                check($sformatf("ctrl_c%0d", c), 32'(sig), 32'(exp_tr(we, c)));
                if (c == 1) check("bus_addr", 32'(bus), 32'(addr));
                if (c == 2 && we) check("bus_wdata", 32'(bus), 32'(wdata));
            end
            if (mem_mio_en) begin
                mio_cyc++;
                rdy = (mio_cyc > rdy_low);
            end
            if (c == gnt_drop) begin
                bus_gnt = 1'b0;
                #1 check("bus_free_on_gnt_loss", 32'(bus_free()), 32'd1);
            end
            if (ack) begin
                ack_sig = sig;
                req = 1'b0;
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rdy = 1'b1;
        req = 1'b0;
    endtask

    int         mc;
    logic [4:0] as;

    initial begin
        preload(8'h00, 16'h1234);
        preload(8'h02, 16'h5A5A);
        @(negedge clk);
        check("rst_outputs",
              32'({ack, err, busy, mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw}),
              32'd0);
        check("rst_rdata", 32'(rdata), 32'h0000);
        check("rst_bus_free", 32'(bus_free()), 32'd1);
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 16'h3000, 16'h0, 0, 16'h1234, 1'b0, 4, 1'b1, 0, mc, as);
        txn(1'b1, 16'h3001, 16'hBEEF, 0, 16'h1234, 1'b0, 4, 1'b1, 0, mc, as);
        txn(1'b0, 16'h3001, 16'h0, 0, 16'hBEEF, 1'b0, 4, 1'b1, 0, mc, as);

        txn(1'b0, 16'h3002, 16'h0, 3, 16'h5A5A, 1'b0, 7, 1'b0, 0, mc, as);
        check("rdy_wait_mio_cycles", 32'(mc), 32'd4);

        txn(1'b0, 16'h3000, 16'h0, 1000, 16'h5A5A, 1'b1, 10, 1'b0, 0, mc, as);
        check("timeout_mio_cycles", 32'(mc), 32'd8);
        check("timeout_ctrl_in_done", 32'(as), 32'd0);

        txn(1'b0, 16'h3000, 16'h0, 0, 16'h5A5A, 1'b1, 2, 1'b0, 1, mc, as);
        bus_gnt = 1'b1;

        // Request held with no grant: bus_req up, master idle, bus untouched.
        bus_gnt = 1'b0;
        req = 1'b1; req_we = 1'b0; req_addr = 16'h3001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_gnt_wait", 32'({bus_req, busy, bus_free()}), 32'b101);
        end
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        txn(1'b0, 16'h3001, 16'h0, 0, 16'hBEEF, 1'b0, 4, 1'b0, 0, mc, as);

        // Reset pulse during WR_MEM: no ack, controls and bus released at once.
        req = 1'b1; req_we = 1'b1; req_addr = 16'h3003; req_wdata = 16'h1111;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("wr_mem_ctrl", 32'({mem_mio_en, mem_rw}), 32'b11);
        req = 1'b0;
        arst_n = 1'b0;
        #1;
        check("async_rst_ctrl",
              32'({ack, err, busy, bus_req, mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw}),
              32'd0);
        check("async_rst_bus_free", 32'(bus_free()), 32'd1);
        check("async_rst_rdata", 32'(rdata), 32'h0000);
        @(posedge clk); #1;
        arst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        txn(1'b0, 16'h3000, 16'h0, 0, 16'h1234, 1'b0, 4, 1'b1, 0, mc, as);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
